// File: rtl/wb_host_master_if.sv
// -----------------------------------------------------------------------------
// wb_host_master_if
// Bundles the three streams handled by wb_host_master:
//   cmd_*  : command stream into the master (valid/ready)
//   rsp_*  : response stream out of the master (valid/ready)
//   wbm_*  : Wishbone classic master port toward the user-project slave
// plus busy_o (master is not idle).
//
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid and ready are both high. The producer holds its payload stable while
// valid is high and ready is low. The consumer may change ready at will.
//
// Modports:
//   master : the view taken by wb_host_master
//   slave  : the opposite view (command source, response sink, Wishbone slave)
// -----------------------------------------------------------------------------
interface wb_host_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_we_i;
  logic [AW-1:0]     cmd_adr_i;
  logic [DW-1:0]     cmd_dat_i;
  logic [DW/8-1:0]   cmd_sel_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DW-1:0]     rsp_dat_o;
  logic              rsp_err_o;

  logic              busy_o;

  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [AW-1:0]     wbm_adr_o;
  logic [DW-1:0]     wbm_dat_o;
  logic [DW/8-1:0]   wbm_sel_o;
  logic              wbm_ack_i;
  logic [DW-1:0]     wbm_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  rsp_ready_i,
    input  wbm_ack_i, wbm_dat_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    output busy_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output rsp_ready_i,
    output wbm_ack_i, wbm_dat_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  busy_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
  );
endinterface

// File: rtl/wb_host_master.sv
// -----------------------------------------------------------------------------
// wb_host_master
// Wishbone classic single-transfer master. Each accepted command becomes one
// bus cycle; the result (read data or timeout error) is returned on the
// response stream. A bus cycle that sees no ack for TIMEOUT_CYCLES cycles is
// abandoned and reported with rsp_err_o=1.
//
// Ports:
//   wb_clk_i     : system clock, rising edge
//   wb_rst_i     : synchronous active-high reset
//   bus          : wb_host_master_if.master (cmd_*, rsp_*, busy_o, wbm_*)
//   dbg_state_o  : current FSM state (0=IDLE, 1=BUS, 2=RESP)
//
// All outputs are registered. stb is identical to cyc (single transfers only).
// -----------------------------------------------------------------------------
module wb_host_master #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_host_master_if.master      bus,
  output logic [1:0]            dbg_state_o
);

  localparam int SW = DW / 8;
  // Timeout fires on the edge where the count of ack-less cycles reaches
  // TIMEOUT_CYCLES, i.e. when the counter already holds TIMEOUT_CYCLES-1.
  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic [15:0]      r_cnt,       w_cnt_nxt;
  logic             r_cyc,       w_cyc_nxt;
  logic             r_we,        w_we_nxt;
  logic [AW-1:0]    r_adr,       w_adr_nxt;
  logic [DW-1:0]    r_dat,       w_dat_nxt;
  logic [SW-1:0]    r_sel,       w_sel_nxt;
  logic             r_cmd_ready, w_cmd_ready_nxt;
  logic             r_busy,      w_busy_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic [DW-1:0]    r_rsp_dat,   w_rsp_dat_nxt;
  logic             r_rsp_err,   w_rsp_err_nxt;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cyc_nxt       = r_cyc;
    w_we_nxt        = r_we;
    w_adr_nxt       = r_adr;
    w_dat_nxt       = r_dat;
    w_sel_nxt       = r_sel;
    w_cmd_ready_nxt = r_cmd_ready;
    w_busy_nxt      = r_busy;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_dat_nxt   = r_rsp_dat;
    w_rsp_err_nxt   = r_rsp_err;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          // Command fields are captured here only; later changes on cmd_*
          // cannot disturb the running bus cycle.
          w_we_nxt        = bus.cmd_we_i;
          w_adr_nxt       = bus.cmd_adr_i;
          w_dat_nxt       = bus.cmd_dat_i;
          w_sel_nxt       = bus.cmd_sel_i;
          w_cyc_nxt       = 1'b1;
          w_cnt_nxt       = 16'd0;
          w_cmd_ready_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = ST_BUS;
        end
      end

      ST_BUS: begin
        if (bus.wbm_ack_i) begin
          // Ack takes priority over a timeout on the same edge.
          w_cyc_nxt       = 1'b0;
          w_rsp_dat_nxt   = r_we ? '0 : bus.wbm_dat_i;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RESP;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_cyc_nxt       = 1'b0;
          w_rsp_dat_nxt   = '0;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      ST_RESP: begin
        // No command is taken on the handshake edge; cmd_ready only rises
        // after it, so the earliest next acceptance is one edge later.
        if (bus.rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_dat_nxt   = '0;
          w_cmd_ready_nxt = 1'b1;
          w_busy_nxt      = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_cyc_nxt       = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_cmd_ready_nxt = 1'b1;
        w_busy_nxt      = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 16'd0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cyc       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_adr       <= w_adr_nxt;
      r_dat       <= w_dat_nxt;
      r_sel       <= w_sel_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_dat   <= w_rsp_dat_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign bus.cmd_ready_o = r_cmd_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_dat_o   = r_rsp_dat;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.busy_o      = r_busy;
  assign bus.wbm_cyc_o   = r_cyc;
  assign bus.wbm_stb_o   = r_cyc;
  assign bus.wbm_we_o    = r_we;
  assign bus.wbm_adr_o   = r_adr;
  assign bus.wbm_dat_o   = r_dat;
  assign bus.wbm_sel_o   = r_sel;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_wb_host_master.sv
// -----------------------------------------------------------------------------
// tb_wb_host_master
// Two masters share one clock: dut_a (timeout 8) and dut_b (timeout 4).
// One set of stimulus variables drives whichever is selected by use_b; the
// other sees cmd_valid/rsp_ready/ack forced low and stays idle.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_host_master;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int T_A = 8;
  localparam int T_B = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  wb_host_master_if #(.AW(AW), .DW(DW)) ifa ();
  wb_host_master_if #(.AW(AW), .DW(DW)) ifb ();
  logic [1:0] dbg_a, dbg_b;

  wb_host_master #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(T_A)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(ifa), .dbg_state_o(dbg_a)
  );
  wb_host_master #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(T_B)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(ifb), .dbg_state_o(dbg_b)
  );

  // ---------------- shared stimulus ----------------
  logic        use_b     = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_we    = 1'b0;
  logic [31:0] cmd_adr   = '0;
  logic [31:0] cmd_dat   = '0;
  logic [3:0]  cmd_sel   = '0;
  logic        rsp_ready = 1'b0;
  logic        ack       = 1'b0;
  logic [31:0] sdat      = '0;

  assign ifa.cmd_valid_i = cmd_valid & ~use_b;
  assign ifb.cmd_valid_i = cmd_valid &  use_b;
  assign ifa.rsp_ready_i = rsp_ready & ~use_b;
  assign ifb.rsp_ready_i = rsp_ready &  use_b;
  assign ifa.wbm_ack_i   = ack & ~use_b;
  assign ifb.wbm_ack_i   = ack &  use_b;
  assign ifa.cmd_we_i  = cmd_we;   assign ifb.cmd_we_i  = cmd_we;
  assign ifa.cmd_adr_i = cmd_adr;  assign ifb.cmd_adr_i = cmd_adr;
  assign ifa.cmd_dat_i = cmd_dat;  assign ifb.cmd_dat_i = cmd_dat;
  assign ifa.cmd_sel_i = cmd_sel;  assign ifb.cmd_sel_i = cmd_sel;
  assign ifa.wbm_dat_i = sdat;     assign ifb.wbm_dat_i = sdat;

  // ---------------- observed outputs of the selected DUT ----------------
  logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_busy, o_cyc, o_stb, o_we;
  logic [31:0] o_rsp_dat, o_adr, o_dat;
  logic [3:0]  o_sel;
  always_comb begin
    o_cmd_ready = use_b ? ifb.cmd_ready_o : ifa.cmd_ready_o;
    o_rsp_valid = use_b ? ifb.rsp_valid_o : ifa.rsp_valid_o;
    o_rsp_err   = use_b ? ifb.rsp_err_o   : ifa.rsp_err_o;
    o_rsp_dat   = use_b ? ifb.rsp_dat_o   : ifa.rsp_dat_o;
    o_busy      = use_b ? ifb.busy_o      : ifa.busy_o;
    o_cyc       = use_b ? ifb.wbm_cyc_o   : ifa.wbm_cyc_o;
    o_stb       = use_b ? ifb.wbm_stb_o   : ifa.wbm_stb_o;
    o_we        = use_b ? ifb.wbm_we_o    : ifa.wbm_we_o;
    o_adr       = use_b ? ifb.wbm_adr_o   : ifa.wbm_adr_o;
    o_dat       = use_b ? ifb.wbm_dat_o   : ifa.wbm_dat_o;
    o_sel       = use_b ? ifb.wbm_sel_o   : ifa.wbm_sel_o;
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one complete transfer ----------------
  // wait_n: slave wait states before ack (ack in cycle wait_n+1 of stb).
  // bp: cycles rsp_ready stays low once the response is up.
  // late_ack: pulse ack during backpressure, which must be ignored.
  task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, input int wait_n, input logic [31:0] rdat,
                         input int bp, input bit late_ack);
    int t_cur, ncyc, ncyc_exp, guard;
    bit exp_err, bus_bad;
    logic [31:0] exp_dat, exp_front;
    // Reference model: bus stays up for min(wait_n+1, timeout) cycles;
    // error when the slave would need longer than the timeout.
    t_cur    = use_b ? T_B : T_A;
    exp_err  = (wait_n + 1) > t_cur;
    ncyc_exp = exp_err ? t_cur : wait_n + 1;
    exp_dat  = (exp_err || we) ? 32'h0 : rdat;
    exp_q.push_back(exp_dat);

    check("cmd_ready_idle", {63'd0, o_cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = wdat; cmd_sel = sel;
    @(negedge clk);
    // Scramble cmd_* after acceptance; the bus must keep the captured values.
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom;
    cmd_sel = 4'($urandom_range(0, 15));
    check("cmd_ready_bus", {63'd0, o_cmd_ready}, 64'd0);

    ncyc = 0; guard = 0; bus_bad = 1'b0;
    while (o_cyc === 1'b1 && guard < 200) begin
      ncyc++; guard++;
      if (o_stb !== 1'b1 || o_we !== we || o_adr !== adr || o_dat !== wdat || o_sel !== sel)
        bus_bad = 1'b1;
      ack  = (ncyc == wait_n + 1);
      sdat = ack ? rdat : $urandom;
      @(negedge clk);
    end
    ack = 1'b0;
    check("bus_fields_held", {63'd0, bus_bad}, 64'd0);
    check("cyc_cycles", 64'(ncyc), 64'(ncyc_exp));
    check("rsp_valid", {63'd0, o_rsp_valid}, 64'd1);
    check("rsp_err", {63'd0, o_rsp_err}, {63'd0, exp_err});
    exp_front = exp_q.pop_front();
    check("rsp_dat", {32'd0, o_rsp_dat}, {32'd0, exp_front});

    for (int i = 0; i < bp; i++) begin
      ack = late_ack && (i == 1);
      sdat = $urandom;
      @(negedge clk);
      ack = 1'b0;
      check("bp_rsp_valid", {63'd0, o_rsp_valid}, 64'd1);
      check("bp_rsp_dat", {32'd0, o_rsp_dat}, {32'd0, exp_front});
      check("bp_rsp_err", {63'd0, o_rsp_err}, {63'd0, exp_err});
      check("bp_cmd_ready", {63'd0, o_cmd_ready}, 64'd0);
      check("bp_cyc", {63'd0, o_cyc}, 64'd0);
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("hs_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
    check("hs_rsp_err", {63'd0, o_rsp_err}, 64'd0);
    check("hs_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);
    check("hs_busy", {63'd0, o_busy}, 64'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit seen;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cyc", {63'd0, o_cyc}, 64'd0);
    check("rst_stb", {63'd0, o_stb}, 64'd0);
    check("rst_we", {63'd0, o_we}, 64'd0);
    check("rst_adr", {32'd0, o_adr}, 64'd0);
    check("rst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
    check("rst_rsp_err", {63'd0, o_rsp_err}, 64'd0);
    check("rst_rsp_dat", {32'd0, o_rsp_dat}, 64'd0);
    check("rst_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait write: one stb cycle, response data 0.
    do_xfer(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 32'h1111_2222, 0, 1'b0);
    // Read with 3 wait states.
    do_xfer(1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF, 3, 32'hDEAD_BEEF, 0, 1'b0);
    // Timeout on dut_a, late ack two cycles after is ignored.
    do_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 20, 32'hCAFE_F00D, 4, 1'b1);
    // Stray ack in IDLE produces nothing.
    ack = 1'b1; sdat = 32'h1234_5678;
    @(negedge clk);
    ack = 1'b0;
    check("idle_ack_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
    check("idle_ack_cyc", {63'd0, o_cyc}, 64'd0);
    check("idle_ack_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);
    // Backpressure for 5 cycles, then a back-to-back command.
    do_xfer(1'b0, 32'h3000_000C, 32'h0, 4'h3, 1, 32'h0BAD_CAFE, 5, 1'b0);
    do_xfer(1'b1, 32'h3000_0010, 32'h7777_8888, 4'hC, 2, 32'hFFFF_FFFF, 0, 1'b0);

    // dut_b (timeout 4): ack on the 4th cycle collides with the timeout.
    use_b = 1'b1;
    @(negedge clk);
    do_xfer(1'b0, 32'h3000_0014, 32'h0, 4'hF, 3, 32'h0000_0055, 1, 1'b0);
    do_xfer(1'b0, 32'h3000_0018, 32'h0, 4'hF, 4, 32'h0000_0066, 0, 1'b0);
    use_b = 1'b0;
    @(negedge clk);

    // Randomized transfers on dut_a; wait states may exceed the timeout.
    repeat (24) begin
      do_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 10)), $urandom, int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset during a BUS wait state.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_cyc", {63'd0, o_cyc}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_cyc", {63'd0, o_cyc}, 64'd0);
    check("mid_rst_stb", {63'd0, o_stb}, 64'd0);
    check("mid_rst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
    check("mid_rst_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);
    check("mid_rst_busy", {63'd0, o_busy}, 64'd0);
    seen = 1'b0;
    ack = 1'b1; sdat = 32'hAAAA_5555;
    @(negedge clk);
    ack = 1'b0;
    repeat (10) begin
      if (o_rsp_valid !== 1'b0 || o_cyc !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    check("post_rst_no_rsp", {63'd0, seen}, 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Wishbone classic single-transfer master. It drives the user-project Wishbone slave port (cyc/stb/we/adr/dat/sel in, ack/dat out) of the AIRISC user project.
- Turns a valid/ready command stream into one bus cycle at a time and returns a response stream.
- Used as the on-chip/test-harness initiator for register access to the core.
- Includes a bus timeout so a non-responding slave cannot hang the host.

Parameters:
- AW, 32, address width of cmd_adr_i / wbm_adr_o
- DW, 32, data width (byte lanes = DW/8)
- TIMEOUT_CYCLES, 255, maximum cycles cyc/stb stay asserted without ack (range 1..65535)

Ports:
- wb_clk_i  in  1  single system clock; all logic on the rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  master can accept a command
- cmd_we_i  in  1  1=write, 0=read
- cmd_adr_i  in  AW  byte address
- cmd_dat_i  in  DW  write data
- cmd_sel_i  in  DW/8  byte enables
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  consumer accepts response
- rsp_dat_o  out  DW  read data (0 for writes and for errors)
- rsp_err_o  out  1  1 = timeout, no ack received
- busy_o  out  1  high in any state other than IDLE
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_adr_o  out  AW  Wishbone address
- wbm_dat_o  out  DW  Wishbone write data
- wbm_sel_o  out  DW/8  Wishbone byte select
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  DW  slave read data

Behaviour:
- Clock and reset: one clock (wb_clk_i); reset wb_rst_i is synchronous, active-high.
- Reset values: all outputs are registered and cleared to 0, except cmd_ready_o=1 (reflects IDLE). State=IDLE, timeout counter=0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i at an edge: capture we/adr/dat/sel into the wbm_* registers, set cyc=stb=1, clear counter, go to BUS.
  - cmd_ready_o drops in the same update.
- BUS:
  - cyc=stb=1, and we/adr/dat/sel are held stable for the whole cycle.
  - Counter increments every cycle in which ack is low.
  - If wbm_ack_i=1 at an edge:
    - cyc=stb=0 at that edge.
    - rsp_dat_o = wbm_dat_i for a read, 0 for a write; rsp_err_o=0.
    - rsp_valid_o=1; go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1:
    - cyc=stb=0, rsp_err_o=1, rsp_dat_o=0, rsp_valid_o=1; go to RESP.
  - Ack and timeout on the same edge: ack wins, no error.
- RESP:
  - Hold rsp_* stable while rsp_ready_i=0.
  - On rsp_ready_i=1 at an edge: rsp_valid_o=0, rsp_err_o=0, cmd_ready_o=1; go to IDLE.
  - No command acceptance in the same cycle as the response handshake.
- Latency:
  - Command accepted at edge N: cyc/stb are high from after N.
  - Zero-wait slave (ack high during cycle N+1): ack sampled at edge N+1; rsp_valid_o high after N+1, cyc low after N+1.
  - Each slave wait state adds one cycle.
  - Throughput is at most one transfer per 3 cycles.
- Timeout: cyc/stb are high for exactly TIMEOUT_CYCLES cycles before dropping.
- Ack handling outside BUS: wbm_ack_i is ignored in IDLE/RESP (e.g. late ack after a timeout); no state change, no response.
- Reset mid-operation: wb_rst_i high at any edge forces IDLE and cyc=stb=rsp_valid=0 from the next cycle. Any pending response is discarded.
- cmd_* inputs are sampled only at the accepting edge; later changes do not affect the running cycle.
- No burst, no retry/err_i, no pipelined mode: classic single transfers only.

Test Plan:
- Write, zero-wait: cmd we=1 adr=0x3000_0004 dat=0xA5A5_1234 sel=0xF, slave acks in first stb cycle → wbm_* carry these values for exactly 1 cycle. Then rsp_valid=1, rsp_err=0, rsp_dat=0 on the next cycle.
- Read with 3 wait states: cmd we=0 adr=0x3000_0000, slave acks on 4th stb cycle with dat=0xDEAD_BEEF → cyc high 4 cycles, rsp_dat=0xDEAD_BEEF, err=0.
- Timeout: TIMEOUT_CYCLES=8, slave never acks → cyc/stb high exactly 8 cycles, then rsp_err=1, rsp_dat=0. A late ack 2 cycles afterward is ignored.
- Ack/timeout collision: TIMEOUT_CYCLES=4, ack on 4th cycle with dat=0x55 → rsp_err=0, rsp_dat=0x55.
- Backpressure: rsp_ready=0 for 5 cycles after response → rsp_* stable, cmd_ready=0. On rsp_ready=1, cmd_ready=1 next cycle, and a back-to-back command starts a new cycle.
- Reset mid-cycle: assert wb_rst_i during BUS wait state → next cycle cyc=stb=rsp_valid=0, cmd_ready=1, and no response is produced afterward.
